// File: rtl/alu_req_sequencer.sv
// Request/response sequencer around a 6-bit signed four-function ALU.
// Requests are accepted in IDLE, executed over one or three cycles, then held in RESP until accepted.
module alu_req_sequencer #(
    parameter bit          SERIAL_MUL3 = 1'b1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [5:0]       req_a,
    input  logic [5:0]       req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [5:0]       rsp_data,
    output logic             rsp_ovf,
    output logic [1:0]       rsp_op,
    output logic [CNT_W-1:0] done_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int unsigned DW = 6;
    localparam int unsigned FW = 9;

    logic [1:0]          state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [DW-1:0]       a_q, a_d;
    logic [DW-1:0]       b_q, b_d;
    logic signed [FW-1:0] acc_q, acc_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]       rsp_data_q, rsp_data_d;
    logic                rsp_ovf_q, rsp_ovf_d;
    logic [1:0]          rsp_op_q, rsp_op_d;
    logic [CNT_W-1:0]    done_cnt_q, done_cnt_d;

    logic signed [FW-1:0] a_x_c, b_x_c, f_c;
    logic signed [DW-1:0] d_wrap_c;
    logic [DW-1:0]        res_data_c;
    logic                 res_ovf_c;

    // Full-precision result from the latched operands; op11 folds the wrapped difference to a magnitude
    always_comb begin
        a_x_c    = {{(FW-DW){a_q[DW-1]}}, a_q};
        b_x_c    = {{(FW-DW){b_q[DW-1]}}, b_q};
        f_c      = '0;
        d_wrap_c = '0;
        case (op_q)
            2'b00:   f_c = (a_x_c <<< 2) + (b_x_c >>> 1);
            2'b01:   f_c = SERIAL_MUL3 ? acc_q : (a_x_c + (b_x_c <<< 1) + b_x_c);
            2'b10:   f_c = -b_x_c;
            default: f_c = (a_x_c <<< 1) - b_x_c;
        endcase
        if (op_q == 2'b11) begin
            d_wrap_c   = f_c[DW-1:0];
            res_data_c = (d_wrap_c > 6'sd0) ? d_wrap_c : -d_wrap_c;
            res_ovf_c  = (f_c > 9'sd31) || (f_c < -9'sd31);
        end else begin
            res_data_c = f_c[DW-1:0];
            res_ovf_c  = (f_c > 9'sd31) || (f_c < -9'sd32);
        end
    end

    // Next-state and output-register logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_op_d    = rsp_op_q;
        done_cnt_d  = done_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d        = req_op;
                    a_d         = req_a;
                    b_d         = req_b;
                    acc_d       = {{(FW-DW){req_a[DW-1]}}, req_a};
                    cnt_d       = (SERIAL_MUL3 && (req_op == 2'b01)) ? 2'd2 : 2'd0;
                    req_ready_d = 1'b0;
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                if (SERIAL_MUL3 && (op_q == 2'b01)) begin
                    acc_d = acc_q + b_x_c;
                end
                if (cnt_q == 2'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RESP: begin
                // First RESP cycle registers the result; it then holds until the consumer takes it
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = res_data_c;
                    rsp_ovf_d   = res_ovf_c;
                    rsp_op_d    = op_q;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    done_cnt_d  = done_cnt_q + CNT_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_op_q    <= '0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_op_q    <= rsp_op_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_op    = rsp_op_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Bench for alu_req_sequencer: directed, random, backpressure, reset and counter-wrap scenarios
// against an integer-arithmetic reference model.
module tb_alu_req_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, rsp_ready;
    logic [1:0] req_op;
    logic [5:0] req_a, req_b;
    logic       req_ready, rsp_valid, rsp_ovf;
    logic [5:0] rsp_data;
    logic [1:0] rsp_op;
    logic [7:0] done_cnt;

    logic       w_req_valid, w_rsp_ready;
    logic       w_req_ready, w_rsp_valid, w_rsp_ovf;
    logic [5:0] w_rsp_data;
    logic [1:0] w_rsp_op;
    logic [1:0] w_done_cnt;

    int vectors = 0;
    int miscompares = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_req_sequencer #(.SERIAL_MUL3(1'b1), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .rsp_op(rsp_op),
        .done_cnt(done_cnt)
    );

    alu_req_sequencer #(.SERIAL_MUL3(1'b0), .CNT_W(2)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .req_valid(w_req_valid), .req_ready(w_req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready),
        .rsp_data(w_rsp_data), .rsp_ovf(w_rsp_ovf), .rsp_op(w_rsp_op),
        .done_cnt(w_done_cnt)
    );

    // Reference: arithmetic on plain integers, straight from the operation definitions
    function automatic void model(input logic [1:0] op, input logic [5:0] a6, input logic [5:0] b6,
                                  output logic [5:0] d, output logic ovf);
        int a, b, f, w, r;
        a = int'($signed(a6));
        b = int'($signed(b6));
        case (op)
            2'd0:    f = 4 * a + (((b < 0) && ((b % 2) != 0)) ? (b / 2 - 1) : (b / 2));
            2'd1:    f = a + 3 * b;
            2'd2:    f = -b;
            default: f = 2 * a - b;
        endcase
        if (op == 2'd3) begin
            w = f;
            while (w > 31) w = w - 64;
            while (w < -32) w = w + 64;
            r = (w > 0) ? w : -w;
            d = 6'(r);
            ovf = ((f < 0) ? -f : f) > 31;
        end else begin
            d = 6'(f);
            ovf = (f < -32) || (f > 31);
        end
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
        return (op == 2'd1) ? 4 : 2;
    endfunction

    task automatic send(input logic [1:0] op, input logic [5:0] a, input logic [5:0] b);
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic ack();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        w_req_valid = 1'b0; w_rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        vectors++; if ({rsp_data, rsp_ovf, rsp_op} !== 9'd0) begin miscompares++; $display("FAIL reset_rsp_fields got %h/%b/%h exp 0", rsp_data, rsp_ovf, rsp_op); end
        vectors++; if (done_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_done_cnt got %0d exp 0", done_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_directed();
        logic [1:0] t_op [0:5];
        logic [5:0] t_a [0:5], t_b [0:5], t_d [0:5];
        logic       t_v [0:5];
        int lat;
        t_op = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        t_a  = '{6'd3, 6'd5, 6'd0, 6'd0, 6'd20, 6'(-3)};
        t_b  = '{6'(-4), 6'd9, 6'(-32), 6'd7, 6'd0, 6'd4};
        t_d  = '{6'd10, 6'b100000, 6'b100000, 6'b111001, 6'd24, 6'd10};
        t_v  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            send(t_op[i], t_a[i], t_b[i]);
            wait_rsp(lat);
            vectors++; if (lat !== exp_lat(t_op[i])) begin miscompares++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, exp_lat(t_op[i])); end
            vectors++; if (rsp_data !== t_d[i]) begin miscompares++; $display("FAIL dir%0d_data got %b exp %b", i, rsp_data, t_d[i]); end
            vectors++; if (rsp_ovf !== t_v[i]) begin miscompares++; $display("FAIL dir%0d_ovf got %b exp %b", i, rsp_ovf, t_v[i]); end
            vectors++; if (rsp_op !== t_op[i]) begin miscompares++; $display("FAIL dir%0d_op got %0d exp %0d", i, rsp_op, t_op[i]); end
            ack();
            exp_cnt = (exp_cnt + 1) % 256;
            vectors++; if (done_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL dir%0d_done_cnt got %0d exp %0d", i, done_cnt, exp_cnt); end
        end
    endtask

    function automatic logic [5:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 6'h20;
            1:       return 6'h1F;
            2:       return 6'h00;
            default: return 6'($urandom);
        endcase
    endfunction

    task automatic test_random();
        logic [1:0] op;
        logic [5:0] a, b, ed;
        logic       ev;
        int lat;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            model(op, a, b, ed, ev);
            vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_ready got %b exp 1", i, req_ready); end
            send(op, a, b);
            wait_rsp(lat);
            vectors++; if (lat !== exp_lat(op)) begin miscompares++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, exp_lat(op)); end
            vectors++; if ({rsp_data, rsp_ovf, rsp_op} !== {ed, ev, op}) begin
                miscompares++;
                $display("FAIL rnd%0d_result op=%0d a=%h b=%h got %h/%b/%0d exp %h/%b/%0d", i, op, a, b, rsp_data, rsp_ovf, rsp_op, ed, ev, op);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            ack();
            exp_cnt = (exp_cnt + 1) % 256;
            vectors++; if (done_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL rnd%0d_done_cnt got %0d exp %0d", i, done_cnt, exp_cnt); end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] op2;
        logic [5:0] a2, b2, ed, ed2;
        logic       ev, ev2;
        int lat;
        model(2'd3, 6'd20, 6'd0, ed, ev);
        send(2'd3, 6'd20, 6'd0);
        wait_rsp(lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL bp_latency got %0d exp 2", lat); end
        @(negedge clk);
        req_valid = 1'b1;
        req_op = 2'($urandom); req_a = 6'($urandom); req_b = 6'($urandom);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            vectors++; if ({rsp_valid, rsp_data, rsp_ovf, rsp_op} !== {1'b1, ed, ev, 2'd3}) begin
                miscompares++;
                $display("FAIL bp_hold%0d got v=%b %h/%b/%0d exp v=1 %h/%b/3", c, rsp_valid, rsp_data, rsp_ovf, rsp_op, ed, ev);
            end
            vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready%0d got %b exp 0", c, req_ready); end
            req_op = 2'($urandom); req_a = 6'($urandom); req_b = 6'($urandom);
        end
        op2 = 2'd1; a2 = 6'(-7); b2 = 6'd4;
        req_op = op2; req_a = a2; req_b = b2;
        model(op2, a2, b2, ed2, ev2);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        vectors++; if (done_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL bp_release_cnt got %0d exp %0d", done_cnt, exp_cnt); end
        vectors++; if ({req_ready, rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL bp_release_state got rdy=%b v=%b exp rdy=1 v=0", req_ready, rsp_valid); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_next_accept got ready=%b exp 0", req_ready); end
        wait_rsp(lat);
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL bp2_latency got %0d exp 4", lat); end
        vectors++; if ({rsp_data, rsp_ovf, rsp_op} !== {ed2, ev2, op2}) begin
            miscompares++;
            $display("FAIL bp2_result got %h/%b/%0d exp %h/%b/%0d", rsp_data, rsp_ovf, rsp_op, ed2, ev2, op2);
        end
        ack();
        exp_cnt = (exp_cnt + 1) % 256;
        vectors++; if (done_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL bp2_done_cnt got %0d exp %0d", done_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid_exec();
        logic [5:0] ed;
        logic       ev;
        int lat;
        send(2'd1, 6'd5, 6'd9);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++; if ({req_ready, rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL rst_exec_async got rdy=%b v=%b exp rdy=1 v=0", req_ready, rsp_valid); end
        vectors++; if (done_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_exec_cnt got %0d exp 0", done_cnt); end
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            vectors++; if ({req_ready, rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL rst_exec_idle%0d got rdy=%b v=%b exp rdy=1 v=0", c, req_ready, rsp_valid); end
        end
        model(2'd0, 6'(-8), 6'd31, ed, ev);
        send(2'd0, 6'(-8), 6'd31);
        wait_rsp(lat);
        vectors++; if ({lat, rsp_data, rsp_ovf} !== {32'd2, ed, ev}) begin
            miscompares++;
            $display("FAIL rst_exec_resume got lat=%0d %h/%b exp lat=2 %h/%b", lat, rsp_data, rsp_ovf, ed, ev);
        end
        ack();
        exp_cnt = 1;
        vectors++; if (done_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL rst_exec_resume_cnt got %0d exp %0d", done_cnt, exp_cnt); end
    endtask

    task automatic test_wrap();
        logic [5:0] ed;
        logic       ev;
        int lat;
        vectors++; if (w_done_cnt !== 2'd0) begin miscompares++; $display("FAIL wrap_start got %0d exp 0", w_done_cnt); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_op = 2'(i); req_a = 6'($urandom); req_b = 6'($urandom);
            model(req_op, req_a, req_b, ed, ev);
            w_req_valid = 1'b1;
            @(posedge clk);
            #1;
            w_req_valid = 1'b0;
            lat = 0;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk);
                #1;
                if (w_rsp_valid) begin lat = k; break; end
            end
            vectors++; if (lat !== 2) begin miscompares++; $display("FAIL wrap%0d_latency got %0d exp 2", i, lat); end
            vectors++; if ({w_rsp_data, w_rsp_ovf, w_rsp_op} !== {ed, ev, 2'(i)}) begin
                miscompares++;
                $display("FAIL wrap%0d_result got %h/%b/%0d exp %h/%b/%0d", i, w_rsp_data, w_rsp_ovf, w_rsp_op, ed, ev, i);
            end
            @(negedge clk);
            w_rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            w_rsp_ready = 1'b0;
            vectors++; if (w_done_cnt !== 2'((i + 1) % 4)) begin miscompares++; $display("FAIL wrap%0d_done_cnt got %0d exp %0d", i, w_done_cnt, (i + 1) % 4); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_exec();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
